// File: rtl/unit_a_serial.sv
// unit_a_serial: multi-cycle add/subtract unit that resolves DIGIT bits of the
// carry chain per clock. It supports add, sub, add-with-carry and
// sub-with-borrow, with the carry flag kept across operations.
// Optional feature macro: UNIT_A_SAT_EN. When it is defined, a signed
// overflow saturates the result.
`timescale 1ns/1ps

module unit_a_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       f,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               last_s;

    // Operands in flight. b_r holds the effective (possibly inverted) operand.
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic               cf_r;

    // Registered outputs.
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   s_r;
    logic               c_out_r;
    logic               ovf_r;
    logic               zero_r;

    // Combinational datapath.
    logic [WIDTH-1:0]   bprime_s;
    logic               cin_s;
    int                 chunk_base_s;
    logic [DIGIT-1:0]   a_chunk_s;
    logic [DIGIT-1:0]   b_chunk_s;
    logic [DIGIT:0]     chunk_s;
    logic [WIDTH-1:0]   full_sum_s;
    logic               ovf_s;
    logic [WIDTH-1:0]   res_s;
    logic               zero_s;

    // Effective operand and carry-in selected from the function code.
    always_comb begin
        bprime_s = f[0] ? ~b : b;
        if (f[1]) begin
            cin_s = cf_r;
        end else begin
            cin_s = f[0];
        end
    end

    // One DIGIT-wide slice of the carry chain plus the assembled sum.
    always_comb begin
        chunk_base_s = int'(idx_r) * DIGIT;
        a_chunk_s    = a_r[chunk_base_s +: DIGIT];
        b_chunk_s    = b_r[chunk_base_s +: DIGIT];
        chunk_s      = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{DIGIT{1'b0}}, carry_r};
        full_sum_s   = sum_r;
        full_sum_s[chunk_base_s +: DIGIT] = chunk_s[DIGIT-1:0];
    end

    // Signed overflow on the raw sum, optional saturation, and zero on the final value.
    always_comb begin
        ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (full_sum_s[WIDTH-1] != a_r[WIDTH-1]);
`ifdef UNIT_A_SAT_EN
        if (ovf_s) begin
            if (a_r[WIDTH-1]) begin
                res_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            res_s = full_sum_s;
        end
`else
        res_s = full_sum_s;
`endif
        zero_s = (res_s == {WIDTH{1'b0}});
    end

    // Next-state logic: accept a request in IDLE, leave RUN after the last chunk.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    last_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, chunk-by-chunk accumulation and result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            cf_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b1;
        end else begin
            busy_r <= (state_nxt_s == ST_RUN);
            done_r <= 1'b0;
            if (accept_s) begin
                a_r     <= a;
                b_r     <= bprime_s;
                carry_r <= cin_s;
                idx_r   <= {IDX_W{1'b0}};
            end else if (state_r == ST_RUN) begin
                sum_r   <= full_sum_s;
                carry_r <= chunk_s[DIGIT];
                idx_r   <= idx_r + IDX_W'(1);
                if (last_s) begin
                    s_r     <= res_s;
                    c_out_r <= chunk_s[DIGIT];
                    ovf_r   <= ovf_s;
                    zero_r  <= zero_s;
                    cf_r    <= chunk_s[DIGIT];
                    done_r  <= 1'b1;
                end
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign s     = s_r;
    assign c_out = c_out_r;
    assign ovf   = ovf_r;
    assign zero  = zero_r;

endmodule

// File: tb/tb_unit_a_serial.sv
// Scoreboard bench for unit_a_serial (WIDTH=32, DIGIT=8) plus an N=1 instance
// (WIDTH=16, DIGIT=16). Honours UNIT_A_SAT_EN in its reference model.
`timescale 1ns/1ps

module tb_unit_a_serial;

    localparam int W = 32;
    localparam int D = 8;
    localparam int N = W / D;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [31:0]   a, b, s;
    logic [1:0]    f;
    logic          busy, done, c_out, ovf, zero;

    logic          start_n1;
    logic [15:0]   a_n1, b_n1, s_n1;
    logic [1:0]    f_n1;
    logic          busy_n1, done_n1, c_out_n1, ovf_n1, zero_n1;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    bit   model_cf = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    unit_a_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .f(f),
        .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    unit_a_serial #(.WIDTH(16), .DIGIT(16)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .start(start_n1), .a(a_n1), .b(b_n1), .f(f_n1),
        .busy(busy_n1), .done(done_n1), .s(s_n1), .c_out(c_out_n1), .ovf(ovf_n1), .zero(zero_n1)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference: arithmetic on wide integers, signed range test for overflow.
    function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb,
                                   input logic [1:0] ff, input bit cfin);
        exp_t        e;
        logic [31:0] beff;
        logic [32:0] wide;
        longint      sgn;
        int          cin;
        beff = ff[0] ? ~bb : bb;
        cin  = ff[1] ? int'(cfin) : int'(ff[0]);
        wide = {1'b0, aa} + {1'b0, beff} + 33'(cin);
        sgn  = longint'($signed(aa)) + longint'($signed(beff)) + longint'(cin);
        e.s  = wide[31:0];
        e.c  = wide[32];
        e.v  = (sgn > 64'sd2147483647) || (sgn < -64'sd2147483648);
`ifdef UNIT_A_SAT_EN
        if (e.v) e.s = aa[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        e.z   = (e.s == 32'h0);
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("s", s, e.s);
                check("c_out", 32'(c_out), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.v));
                check("zero", 32'(zero), 32'(e.z));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Issue one operation; returns right after the done edge so the next
    // call starts in the done cycle (back-to-back).
    task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic [1:0] ff);
        exp_t e;
        a = aa; b = bb; f = ff; start = 1'b1;
        @(posedge clk); #1;
        e = model(aa, bb, ff, model_cf);
        e.cyc = cyc + N;
        model_cf = e.c;
        sb_q.push_back(e);
        check("busy_after_accept", 32'(busy), 32'd1);
        start = 1'b0;
        a = $urandom; b = $urandom; f = 2'($urandom_range(0, 3));
        repeat (N) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0; f = 2'b00;
        start_n1 = 1'b0; a_n1 = 16'h0; b_n1 = 16'h0; f_n1 = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", s, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_zero_n1", 32'(zero_n1), 32'd1);
        rst_n = 1'b1;

        // Directed vectors, including the carry chain started in the done cycle.
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 2'b00);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 2'b01);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        run_op(32'h0000_0000, 32'h0000_0000, 2'b10);
        run_op(32'h0000_0000, 32'h0000_0001, 2'b01);
        run_op(32'h0000_0000, 32'h0000_0000, 2'b11);

        // Randomized back-to-back traffic with corner operands mixed in.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
            run_op(ra, rb, 2'($urandom_range(0, 3)));
        end
        repeat (2) @(posedge clk);
        #1;

        // start while busy is ignored; exactly one done with the first result.
        a = 32'h1; b = 32'h2; f = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        e = model(32'h1, 32'h2, 2'b00, model_cf);
        e.cyc = cyc + N;
        model_cf = e.c;
        sb_q.push_back(e);
        start = 1'b0;
        @(posedge clk); #1;
        a = 32'h5; b = 32'h5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_ignored_start", 32'(busy), 32'd1);
        repeat (6) @(posedge clk);
        #1;

        // Set cf=1, then abort an operation with reset at E+2.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        a = 32'h1; b = 32'h2; f = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s", s, 32'h0);
        check("abort_zero", 32'(zero), 32'd1);
        check("abort_c_out", 32'(c_out), 32'd0);
        rst_n = 1'b1;
        model_cf = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        run_op(32'h0000_0000, 32'h0000_0000, 2'b10);
        repeat (2) @(posedge clk);
        #1;

        // N=1 configuration: done one edge after accept.
        a_n1 = 16'h8000; b_n1 = 16'h0001; f_n1 = 2'b01; start_n1 = 1'b1;
        @(posedge clk); #1;
        start_n1 = 1'b0;
        check("n1_busy_after_accept", 32'(busy_n1), 32'd1);
        check("n1_done_early", 32'(done_n1), 32'd0);
        @(posedge clk); #1;
        check("n1_done", 32'(done_n1), 32'd1);
        check("n1_busy", 32'(busy_n1), 32'd0);
`ifdef UNIT_A_SAT_EN
        check("n1_s", 32'(s_n1), 32'h0000_8000);
`else
        check("n1_s", 32'(s_n1), 32'h0000_7FFF);
`endif
        check("n1_ovf", 32'(ovf_n1), 32'd1);
        check("n1_c_out", 32'(c_out_n1), 32'd1);
        check("n1_zero", 32'(zero_n1), 32'd0);
        @(posedge clk); #1;
        check("n1_done_pulse_end", 32'(done_n1), 32'd0);

        // Every expected result must have been consumed within the budget.
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
